// File: rtl/io_rx_buffer_pkg.sv
// Shared widths, byte-counter type and packer state encodings
// for the peripheral receive buffer.
package io_pkg;

  localparam int IO_WORD_W         = 32;
  localparam int IO_BYTE_W         = 8;
  localparam int IO_BYTES_PER_WORD = 4;

  typedef logic [1:0] byte_cnt_t;

  localparam byte_cnt_t BYTE0 = 2'd0;
  localparam byte_cnt_t BYTE1 = 2'd1;
  localparam byte_cnt_t BYTE2 = 2'd2;
  localparam byte_cnt_t BYTE3 = 2'd3;

endpackage

// File: rtl/io_rx_buffer_if.sv
// Byte-in / word-out bus between the I/O device, the receive buffer and the DMA.
// Master is the device/DMA side; slave is the buffer itself.
interface io_rx_buffer_if
  import io_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                 byte_valid;
  logic [IO_BYTE_W-1:0] byte_data;
  logic                 flush;
  logic                 dma_ack;
  logic [IO_WORD_W-1:0] io_data;
  logic                 new_data_ready;
  logic                 overflow;
  logic [LVL_W-1:0]     level;

  modport master (
    output byte_valid, byte_data, flush, dma_ack,
    input  io_data, new_data_ready, overflow, level
  );

  modport slave (
    input  byte_valid, byte_data, flush, dma_ack,
    output io_data, new_data_ready, overflow, level
  );

endinterface

// File: rtl/io_word_fifo.sv
// First-word-fall-through word FIFO with extra-MSB pointers; a push into a full
// FIFO is accepted only when a pop frees the head slot on the same edge.
module io_word_fifo
  import io_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [IO_WORD_W-1:0]       data_i,
  input  logic                       pop_i,
  output logic [IO_WORD_W-1:0]       data_o,
  output logic                       push_accept_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = PW - 1;

  logic [IO_WORD_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic                 pop_ok, push_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  assign push_accept_o = push_ok;
  assign level_o       = wr_q - rd_q;
  assign data_o        = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + PW'(1);
      if (pop_ok)  rd_d = rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: data_o is gated to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!flush_i && push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/io_rx_buffer.sv
// Packs little-endian bytes into 32-bit words, queues them for the DMA and
// records dropped words in a sticky overflow flag.
module io_rx_buffer
  import io_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  io_rx_buffer_if.slave bus
);

  localparam int PART_W = IO_BYTE_W * (IO_BYTES_PER_WORD - 1);

  byte_cnt_t           cnt_q, cnt_d;
  logic [PART_W-1:0]   partial_q, partial_d;
  logic                overflow_q, overflow_d;
  logic                word_done;
  logic                push_accept;
  logic                fifo_full, fifo_empty;
  logic [IO_WORD_W-1:0] fifo_head;

  assign word_done = bus.byte_valid && !bus.flush && (cnt_q == BYTE3);

  io_word_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (bus.flush),
    .push_i        (word_done),
    .data_i        ({bus.byte_data, partial_q}),
    .pop_i         (bus.dma_ack),
    .data_o        (fifo_head),
    .push_accept_o (push_accept),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .level_o       (bus.level)
  );

  assign bus.io_data        = fifo_head;
  assign bus.new_data_ready = !fifo_empty;
  assign bus.overflow       = overflow_q;

  // Flush wins over any byte presented in the same cycle; the byte is lost.
  always_comb begin
    cnt_d      = cnt_q;
    partial_d  = partial_q;
    overflow_d = overflow_q;
    if (bus.flush) begin
      cnt_d      = BYTE0;
      partial_d  = '0;
      overflow_d = 1'b0;
    end else if (bus.byte_valid) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        BYTE0:   partial_d[7:0]   = bus.byte_data;
        BYTE1:   partial_d[15:8]  = bus.byte_data;
        BYTE2:   partial_d[23:16] = bus.byte_data;
        default: partial_d        = '0;
      endcase
      if (word_done && !push_accept) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= BYTE0;
      partial_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      partial_q  <= partial_d;
      overflow_q <= overflow_d;
    end
  end

  // Full is only consumed through push_accept; kept on the FIFO for reuse.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule
